// File: rtl/rtr_route_gen.sv
// rtl/rtr_route_gen.sv - per-input-VC phased-DOR route generator; optional error checks under RTR_ROUTE_GEN_CHECK_EN
module rtr_route_gen #(
  parameter int num_dimensions       = 2,
  parameter int dim_addr_width       = 2,
  parameter int num_nodes_per_router = 1,
  parameter int num_ports            = 5,
  parameter int num_resource_classes = 2,
  parameter int num_vcs_per_class    = 1,
  parameter int vc_id                = 0,
  parameter logic [num_dimensions*dim_addr_width-1:0] router_address = '0
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    flit_valid,
  input  logic                                    flit_head,
  input  logic                                    flit_tail,
  input  logic [num_dimensions*dim_addr_width-1:0] dest_router,
  input  logic [((num_nodes_per_router > 1) ? $clog2(num_nodes_per_router) : 1)-1:0] dest_node,
  input  logic                                    phase_done,
  output logic                                    route_valid,
  output logic [num_ports-1:0]                    route_op,
  output logic [num_resource_classes-1:0]         route_orc,
  output logic [1:0]                              errors
);

  localparam int resource_class = (vc_id / num_vcs_per_class) % num_resource_classes;
  localparam int last_class     = num_resource_classes - 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                          state, state_d;
  int                              port_idx;
  int                              out_class;
  logic                            eject_bad;
  logic                            head_acc;
  logic [num_ports-1:0]            calc_op;
  logic [num_resource_classes-1:0] calc_orc;
  logic                            valid_d;
  logic [num_ports-1:0]            op_d;
  logic [num_resource_classes-1:0] orc_d;

  assign head_acc = flit_valid & flit_head;

  // Dimension-order route and output class from the head inputs; one-hot vectors put index 0 at the MSB
  always_comb begin
    port_idx = 2*num_dimensions + int'(dest_node);
    // Descending scan so the lowest differing dimension wins
    for (int d = num_dimensions-1; d >= 0; d--) begin
      if (dest_router[d*dim_addr_width +: dim_addr_width] !=
          router_address[d*dim_addr_width +: dim_addr_width]) begin
        if (dest_router[d*dim_addr_width +: dim_addr_width] <
            router_address[d*dim_addr_width +: dim_addr_width])
          port_idx = 2*d;
        else
          port_idx = 2*d + 1;
      end
    end
    eject_bad = (port_idx >= num_ports);
    for (int i = 0; i < num_ports; i++)
      calc_op[i] = !eject_bad && (port_idx == num_ports-1-i);
    // Last class cannot advance; it keeps its own class
    out_class = (phase_done && (resource_class < last_class)) ? resource_class + 1 : resource_class;
    for (int i = 0; i < num_resource_classes; i++)
      calc_orc[i] = (out_class == last_class - i);
  end

  // Next-state and route-register logic: load on head, hold through body, clear on tail
  always_comb begin
    state_d = state;
    valid_d = route_valid;
    op_d    = route_op;
    orc_d   = route_orc;
    case (state)
      IDLE: begin
        valid_d = 1'b0;
        op_d    = '0;
        orc_d   = '0;
        if (head_acc) begin
          valid_d = 1'b1;
          op_d    = calc_op;
          orc_d   = calc_orc;
          state_d = flit_tail ? IDLE : ACTIVE;
        end
      end
      ACTIVE: begin
        if (head_acc) begin
          valid_d = 1'b1;
          op_d    = calc_op;
          orc_d   = calc_orc;
          state_d = flit_tail ? IDLE : ACTIVE;
        end else if (flit_valid && flit_tail) begin
          valid_d = 1'b0;
          op_d    = '0;
          orc_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and held route registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      route_valid <= 1'b0;
      route_op    <= '0;
      route_orc   <= '0;
    end else begin
      state       <= state_d;
      route_valid <= valid_d;
      route_op    <= op_d;
      route_orc   <= orc_d;
    end
  end

`ifdef RTR_ROUTE_GEN_CHECK_EN
  logic proto_err;
  logic ovf_err;

  // Protocol violations: head mid-packet, non-head while idle, or ejection port out of range
  always_comb begin
    proto_err = (flit_valid && ((state == ACTIVE && flit_head) || (state == IDLE && !flit_head)))
                || (head_acc && eject_bad);
    ovf_err   = head_acc && phase_done && (resource_class == last_class);
  end

  // One-cycle registered error pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) errors <= 2'b00;
    else       errors <= {ovf_err, proto_err};
  end
`else
  assign errors = 2'b00;
`endif

endmodule

// File: tb/tb_rtr_route_gen.sv
// tb/tb_rtr_route_gen.sv - scoreboard bench for rtr_route_gen (vc_id 0 and 1 instances side by side)
module tb_rtr_route_gen;

`ifdef RTR_ROUTE_GEN_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  localparam logic [3:0] RADDR = 4'b1001; // x=1, y=2

  logic       clk = 1'b0;
  logic       reset;
  logic       flit_valid, flit_head, flit_tail;
  logic [3:0] dest_router;
  logic [0:0] dest_node;
  logic       phase_done;

  logic       v0, v1;
  logic [4:0] op0, op1;
  logic [1:0] orc0, orc1, err0, err1;

  typedef struct packed {
    logic       v;
    logic [4:0] op;
    logic [1:0] orc0;
    logic [1:0] orc1;
    logic [1:0] e0;
    logic [1:0] e1;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    checks = 0;
  int    errs   = 0;

  always #5 clk = ~clk;

  rtr_route_gen #(.vc_id(0), .router_address(RADDR)) dut0 (
    .clk(clk), .reset(reset), .flit_valid(flit_valid), .flit_head(flit_head),
    .flit_tail(flit_tail), .dest_router(dest_router), .dest_node(dest_node),
    .phase_done(phase_done), .route_valid(v0), .route_op(op0), .route_orc(orc0),
    .errors(err0));

  rtr_route_gen #(.vc_id(1), .router_address(RADDR)) dut1 (
    .clk(clk), .reset(reset), .flit_valid(flit_valid), .flit_head(flit_head),
    .flit_tail(flit_tail), .dest_router(dest_router), .dest_node(dest_node),
    .phase_done(phase_done), .route_valid(v1), .route_op(op1), .route_orc(orc1),
    .errors(err1));

  task automatic push(input logic ev, input logic [4:0] eop, input logic [1:0] eo0,
                      input logic [1:0] eo1, input logic pe, input logic oe1, input string nm);
    exp_t e;
    e.v    = ev;
    e.op   = eop;
    e.orc0 = eo0;
    e.orc1 = eo1;
    e.e0   = {1'b0, CHK & pe};
    e.e1   = {CHK & oe1, CHK & pe};
    q.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic step(input logic fv, input logic fh, input logic ft, input logic [3:0] dr,
                      input logic dn, input logic pd, input logic ev, input logic [4:0] eop,
                      input logic [1:0] eo0, input logic [1:0] eo1, input logic pe,
                      input logic oe1, input string nm);
    @(negedge clk);
    flit_valid  = fv;
    flit_head   = fh;
    flit_tail   = ft;
    dest_router = dr;
    dest_node   = dn;
    phase_done  = pd;
    push(ev, eop, eo0, eo1, pe, oe1, nm);
  endtask

  // Monitor: pops one expectation per clock edge or asynchronous reset assertion
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk or posedge reset);
      #2;
      if (q.size() > 0) begin
        e  = q.pop_front();
        nm = nq.pop_front();
        checks++;
        if (v0 !== e.v || v1 !== e.v || op0 !== e.op || op1 !== e.op ||
            orc0 !== e.orc0 || orc1 !== e.orc1 || err0 !== e.e0 || err1 !== e.e1) begin
          errs++;
          $display("FAIL %s got v=%b/%b op=%b/%b orc=%b/%b err=%b/%b need v=%b op=%b orc=%b/%b err=%b/%b",
                   nm, v0, v1, op0, op1, orc0, orc1, err0, err1,
                   e.v, e.op, e.orc0, e.orc1, e.e0, e.e1);
        end
      end
    end
  end

  initial begin
    reset       = 1'b1;
    flit_valid  = 1'b0;
    flit_head   = 1'b0;
    flit_tail   = 1'b0;
    dest_router = 4'b0000;
    dest_node   = 1'b0;
    phase_done  = 1'b0;

    step(0,0,0,4'b0000,0,0, 0,5'b00000,2'b00,2'b00, 0,0, "reset_a");
    step(0,0,0,4'b0000,0,0, 0,5'b00000,2'b00,2'b00, 0,0, "reset_b");
    @(negedge clk);
    reset = 1'b0;

    //   fv fh ft dest     dn pd  v  op       orc0  orc1  pe oe1
    step(1,1,0,4'b0011,0,0, 1,5'b01000,2'b10,2'b01, 0,0, "head_x3y0");
    step(1,0,0,4'b0011,0,0, 1,5'b01000,2'b10,2'b01, 0,0, "body_hold1");
    step(0,0,0,4'b0000,0,0, 1,5'b01000,2'b10,2'b01, 0,0, "idle_hold");
    step(1,0,1,4'b0000,0,0, 0,5'b00000,2'b00,2'b00, 0,0, "tail_clear");
    step(0,0,0,4'b0000,0,0, 0,5'b00000,2'b00,2'b00, 0,0, "idle_after_tail");
    step(1,1,1,4'b0001,0,0, 1,5'b00100,2'b10,2'b01, 0,0, "single_x1y0");
    step(0,0,0,4'b0000,0,0, 0,5'b00000,2'b00,2'b00, 0,0, "single_drop");
    step(1,1,1,4'b1001,0,0, 1,5'b00001,2'b10,2'b01, 0,0, "single_eject");
    step(1,1,0,4'b1000,0,1, 1,5'b10000,2'b01,2'b01, 0,1, "head_x0_phase");
    step(0,0,0,4'b0000,0,0, 1,5'b10000,2'b01,2'b01, 0,0, "phase_hold");
    step(1,1,0,4'b1101,0,0, 1,5'b00010,2'b10,2'b01, 1,0, "head_in_active");
    step(1,0,1,4'b0000,0,0, 0,5'b00000,2'b00,2'b00, 0,0, "tail_clear2");
    step(1,0,0,4'b0000,0,0, 0,5'b00000,2'b00,2'b00, 1,0, "body_in_idle");
    step(1,1,1,4'b1001,1,0, 1,5'b00000,2'b10,2'b01, 1,0, "eject_overrange");
    step(1,1,0,4'b0011,0,0, 1,5'b01000,2'b10,2'b01, 0,0, "head_again");
    step(1,0,0,4'b0011,0,0, 1,5'b01000,2'b10,2'b01, 0,0, "body_hold2");

    // Asynchronous reset between edges while a packet is in progress
    @(posedge clk);
    #4;
    flit_valid = 1'b0;
    push(0,5'b00000,2'b00,2'b00, 0,0, "async_reset");
    reset = 1'b1;
    @(negedge clk);
    push(0,5'b00000,2'b00,2'b00, 0,0, "reset_hold");
    @(negedge clk);
    reset = 1'b0;

    step(1,0,0,4'b0011,0,0, 0,5'b00000,2'b00,2'b00, 1,0, "body_after_reset");
    step(0,0,0,4'b0000,0,0, 0,5'b00000,2'b00,2'b00, 0,0, "final_idle");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    #3;
    if (q.size() > 0) begin
      errs++;
      $display("FAIL drain got %0d pending need 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule
